flood_board_gen: RTL
====================

Name: flood_board_gen

Overview:
Parametrised next-generation Flood-It board generator. On request it fills a SIZE x SIZE board with pseudo-random colours drawn from a 16-bit LFSR and writes one cell per write strobe into an external board RAM, not a wide array output. Colours are uniform by rejection sampling over any colour count. An optional mode forbids a cell from matching its left neighbour. It sits between the game-control FSM (START/READY handshake) and the board RAM that the flood-fill and VGA logic read.

Parameters:
MAX_SIZE, 26, largest board edge; RAM holds MAX_SIZE*MAX_SIZE cells, row-major.
MAX_COLORS, 8, largest colour count; COLOR_W = clog2(MAX_COLORS) (3 at default).
ADDR_W, 10, width of the RAM address; must satisfy 2^ADDR_W >= MAX_SIZE*MAX_SIZE.
RETRY_MAX, 15, maximum consecutive rejected draws before the fallback colour is used.
DEFAULT_SEED, 16'hDAD7, LFSR load value when SEED==0.

Ports:
CLOCK  in  1  system clock; all logic on the rising edge.
RESET  in  1  synchronous, active-high reset.
START  in  1  level request for a new board.
SEED  in  16  LFSR seed, sampled on accepted START.
SIZE  in  5  board edge, sampled on accepted START.
COLOR_NUM  in  4  colour count, sampled on accepted START.
NO_REPEAT  in  1  1 = cell may not equal its left neighbour; sampled on accepted START.
WE  out  1  board RAM write strobe, one cycle per cell.
ADDR  out  ADDR_W  RAM address = ROW*MAX_SIZE + COL.
DATA  out  COLOR_W  colour written.
BUSY  out  1  high from the cycle after START is accepted until the last write.
READY  out  1  board complete.

Behaviour:
- Reset values: WE=0, ADDR=0, DATA=0, BUSY=0, READY=0, state=IDLE, LFSR=DEFAULT_SEED, ROW=COL=0, retry counter=0, left-colour register invalid.
- LFSR: R <= {R[14:0], R[15]^R[13]^R[12]^R[10]}. It advances once per STEP cycle only. R is never 0, because seed 0 is replaced by DEFAULT_SEED.
- Sampling and clamping on START acceptance:
  - SIZE<2 becomes 2; SIZE>MAX_SIZE becomes MAX_SIZE.
  - COLOR_NUM<2 becomes 2; COLOR_NUM>MAX_COLORS becomes MAX_COLORS.
  - Latched values do not change until the next acceptance.
- IDLE: if START=1 and READY=0, load R, ROW=0, COL=0, retry=0, mark the left colour invalid, then go to STEP.
- STEP (BUSY=1):
  - Candidate c = R[COLOR_W-1:0] of the current R (before this cycle's shift).
  - Accept if c < N and not (NO_REPEAT and left valid and c == left).
  - On accept: latch DATA=c, go to WRITE.
  - On reject: retry+1. If retry reaches RETRY_MAX, use fallback colour (left+1) mod N (0 if left is invalid) and go to WRITE. Otherwise stay in STEP.
- WRITE (BUSY=1):
  - WE=1 for exactly this cycle, with ADDR and DATA.
  - Left register = DATA and is marked valid; retry=0.
  - If COL+1==SIZE: COL=0, ROW+1, left marked invalid (rows are independent). Otherwise COL+1.
  - If this was the last cell (ROW==SIZE-1, COL==SIZE-1), go to DONE. Otherwise go to STEP.
- DONE: BUSY=0, READY=1. READY holds until START is sampled low, then READY=0 and state returns to IDLE. START held high does not retrigger generation.
- Latency: START accepted at cycle t. First STEP at t+1. With no rejections the first WE is at t+2. The minimum total is 2*SIZE^2 cycles from t+1 to the last WE; READY rises the cycle after the last WE.
- START is ignored while BUSY or READY.
- RESET mid-operation aborts immediately to reset values; no further WE. Partial RAM contents are left as written.
- Arithmetic: ROW*MAX_SIZE+COL is computed at ADDR_W width with no overflow, guaranteed by the ADDR_W constraint.

Test Plan:
- Seed 16'h0001, SIZE=2, COLOR_NUM=3, NO_REPEAT=0, START at cycle 0 -> STEP at cycle 1 with candidate 1 accepted; WE at cycle 2 with ADDR=0, DATA=1; exactly 4 WE pulses at ADDR 0,1,26,27; READY=1 on the cycle after the 4th WE.
- Seed 0 vs seed 16'hDAD7, same SIZE/COLOR_NUM -> identical WE/ADDR/DATA sequences.
- SIZE=31 and SIZE=0 -> clamped to 26 (676 writes, last ADDR=675) and to 2 (4 writes). COLOR_NUM=1 -> all DATA<2. COLOR_NUM=8 -> no rejections, 2 cycles per cell.
- NO_REPEAT=1, COLOR_NUM=2, SIZE=8 -> within every row, adjacent DATA differ (alternating pattern); every DATA<2; a bench monitor counts rejections and checks the fallback colour after RETRY_MAX rejections.
- Handshake: hold START high after READY -> no new writes; drop START -> READY falls next cycle; START pulses while BUSY -> ignored.
- RESET asserted during the 3rd STEP of a SIZE=4 run -> WE=0, BUSY=0, READY=0 the next cycle; a new START then regenerates the board from cell 0 with the new seed.

Source files
------------

// File: rtl/flood_board_gen.sv
// flood_board_gen: fills a SIZE x SIZE Flood-It board with LFSR colours, one RAM write per cell.
// Revision 1.0 - initial release.
`default_nettype none

module flood_board_gen #(
  parameter int          MAX_SIZE     = 26,
  parameter int          MAX_COLORS   = 8,
  parameter int          ADDR_W       = 10,
  parameter int          RETRY_MAX    = 15,
  parameter logic [15:0] DEFAULT_SEED = 16'hDAD7,
  localparam int         COLOR_W      = $clog2(MAX_COLORS)
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [15:0]        SEED,
  input  logic [4:0]         SIZE,
  input  logic [3:0]         COLOR_NUM,
  input  logic               NO_REPEAT,
  output logic               WE,
  output logic [ADDR_W-1:0]  ADDR,
  output logic [COLOR_W-1:0] DATA,
  output logic               BUSY,
  output logic               READY
);

  localparam int CNT_W = COLOR_W + 1;
  localparam int RTY_W = $clog2(RETRY_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [15:0]        lfsr;
  logic [4:0]         row, col, size_q;
  logic [CNT_W-1:0]   ncol_q;
  logic               norep_q;
  logic [RTY_W-1:0]   retry;
  logic [COLOR_W-1:0] left, data_q;
  logic               left_valid;

  logic [COLOR_W-1:0] cand;
  logic               cand_ok;
  logic [RTY_W-1:0]   retry_inc;
  logic               retry_done;
  logic [CNT_W-1:0]   left_inc;
  logic [COLOR_W-1:0] fallback;
  logic               last_col, last_cell;
  logic [4:0]         size_in;
  logic [CNT_W-1:0]   ncol_in;
  logic               lfsr_fb;

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand       = lfsr[COLOR_W-1:0];
  assign cand_ok    = ({1'b0, cand} < ncol_q) && !(norep_q && left_valid && (cand == left));
  assign retry_inc  = retry + RTY_W'(1);
  assign retry_done = (retry_inc == RTY_W'(RETRY_MAX));
  assign left_inc   = {1'b0, left} + CNT_W'(1);
  // Fallback steps past the left colour so NO_REPEAT still holds after exhausting retries.
  assign fallback   = (!left_valid || (left_inc == ncol_q)) ? '0 : left_inc[COLOR_W-1:0];
  assign last_col   = (col == size_q - 5'd1);
  assign last_cell  = last_col && (row == size_q - 5'd1);

  assign size_in = (SIZE < 5'd2)          ? 5'd2 :
                   (SIZE > 5'(MAX_SIZE))  ? 5'(MAX_SIZE) : SIZE;
  assign ncol_in = (COLOR_NUM < 4'd2)                ? CNT_W'(2) :
                   (32'(COLOR_NUM) > 32'(MAX_COLORS)) ? CNT_W'(MAX_COLORS) : CNT_W'(COLOR_NUM);

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_STEP;
      S_STEP:  if (cand_ok || retry_done) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_cell ? S_DONE : S_STEP;
      S_DONE:  if (!START) state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      lfsr       <= DEFAULT_SEED;
      row        <= '0;
      col        <= '0;
      retry      <= '0;
      left       <= '0;
      left_valid <= 1'b0;
      data_q     <= '0;
      size_q     <= 5'd2;
      ncol_q     <= CNT_W'(2);
      norep_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          lfsr       <= (SEED == 16'd0) ? DEFAULT_SEED : SEED;
          row        <= '0;
          col        <= '0;
          retry      <= '0;
          left_valid <= 1'b0;
          size_q     <= size_in;
          ncol_q     <= ncol_in;
          norep_q    <= NO_REPEAT;
        end
        S_STEP: begin
          lfsr <= {lfsr[14:0], lfsr_fb};
          if (cand_ok) begin
            data_q <= cand;
          end else begin
            retry <= retry_inc;
            if (retry_done) data_q <= fallback;
          end
        end
        S_WRITE: begin
          left  <= data_q;
          retry <= '0;
          // Each row starts without a left neighbour.
          if (last_col) begin
            col        <= '0;
            row        <= row + 5'd1;
            left_valid <= 1'b0;
          end else begin
            col        <= col + 5'd1;
            left_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    WE    = (state == S_WRITE);
    BUSY  = (state == S_STEP) || (state == S_WRITE);
    READY = (state == S_DONE);
    ADDR  = ADDR_W'(row) * ADDR_W'(MAX_SIZE) + ADDR_W'(col);
    DATA  = data_q;
  end

endmodule

`default_nettype wire
